// File: rtl/red_pkg.sv
// Shared types and constants for the nibble-reduction (RED) sequencer.
// Holds the FSM state encoding and the sign-extension helpers.
package red_pkg;

  localparam int NIB_W = 4;
  localparam int ACC_W = 8;
  localparam int NIBS  = 4;
  localparam int RED_W = 16;
  localparam int CNT_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic [ACC_W-1:0] sext_nib(input logic [NIB_W-1:0] nib);
    return {{(ACC_W-NIB_W){nib[NIB_W-1]}}, nib};
  endfunction

  function automatic logic [RED_W-1:0] sext_acc(input logic [ACC_W-1:0] acc);
    return {{(RED_W-ACC_W){acc[ACC_W-1]}}, acc};
  endfunction

endpackage

// File: rtl/red_seq_ctrl_if.sv
// Operand/result handshake bundle between the EX stage and the RED sequencer.
// The master drives operands and flush; the slave returns the result and status.
interface red_seq_ctrl_if;
  import red_pkg::*;

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [RED_W-1:0] in_a;
  logic [RED_W-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [RED_W-1:0] out_sum;
  logic             busy;

  modport master (
    output flush, in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_sum, busy
  );

  modport slave (
    input  flush, in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_sum, busy
  );

endinterface

// File: rtl/red_step.sv
// One fold step: adds the sign-extended nibble pairs starting at nibble cnt
// into the 8-bit accumulator; NIB_PER_CYC pairs are folded per call.
module red_step
  import red_pkg::*;
#(
  parameter int NIB_PER_CYC = 1
) (
  input  logic [ACC_W-1:0] acc_i,
  input  logic [RED_W-1:0] op_a,
  input  logic [RED_W-1:0] op_b,
  input  logic [CNT_W-1:0] cnt,
  output logic [ACC_W-1:0] acc_o
);

  logic [CNT_W-1:0] nib_idx;
  logic [ACC_W-1:0] sum;

  // The range is bounded to -64..+56, so the 8-bit sum never wraps.
  always_comb begin
    nib_idx = '0;
    sum     = acc_i;
    for (int k = 0; k < NIB_PER_CYC; k++) begin
      nib_idx = cnt + CNT_W'(k);
      sum = sum + sext_nib(op_a[{nib_idx, 2'b00} +: NIB_W])
                + sext_nib(op_b[{nib_idx, 2'b00} +: NIB_W]);
    end
  end

  assign acc_o = sum;

endmodule

// File: rtl/red_seq_ctrl.sv
// Multi-cycle RED sequencer: folds four nibble pairs into an 8-bit accumulator
// over 4/NIB_PER_CYC cycles and presents the sign-extended sum via valid/ready.
module red_seq_ctrl
  import red_pkg::*;
#(
  parameter int NIB_PER_CYC = 1
) (
  input  logic         clk,
  input  logic         rst,
  red_seq_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_STEP = CNT_W'(NIB_PER_CYC % NIBS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBS - NIB_PER_CYC);

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RED_W-1:0] op_a_q, op_a_d;
  logic [RED_W-1:0] op_b_q, op_b_d;
  logic             out_valid_q, out_valid_d;
  logic [RED_W-1:0] out_sum_q, out_sum_d;
  logic             busy_q, busy_d;

  logic [ACC_W-1:0] step_acc;
  logic             in_ready;
  logic             accept;

  red_step #(
    .NIB_PER_CYC(NIB_PER_CYC)
  ) u_step (
    .acc_i (acc_q),
    .op_a  (op_a_q),
    .op_b  (op_b_q),
    .cnt   (cnt_q),
    .acc_o (step_acc)
  );

  assign in_ready = (state_q == IDLE) | ((state_q == DONE) & bus.out_ready);
  assign accept   = bus.in_valid & in_ready;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          op_a_d  = bus.in_a;
          op_b_d  = bus.in_b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        acc_d = step_acc;
        cnt_d = cnt_q + CNT_STEP;
        if (cnt_q == LAST_CNT) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          out_sum_d   = sext_acc(step_acc);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          out_sum_d   = '0;
          if (bus.in_valid) begin
            op_a_d  = bus.in_a;
            op_b_d  = bus.in_b;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = ACCUM;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Squash beats both a new accept and a pending handoff.
    if (bus.flush) begin
      state_d     = IDLE;
      acc_d       = '0;
      cnt_d       = '0;
      out_valid_d = 1'b0;
      out_sum_d   = '0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_red_seq_ctrl.sv
// Directed bench for red_seq_ctrl: one instance per NIB_PER_CYC value (1, 2, 4),
// hand-computed sums and latencies, backpressure, flush and mid-op reset.
module tb_red_seq_ctrl;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  red_seq_ctrl_if b1 ();
  red_seq_ctrl_if b2 ();
  red_seq_ctrl_if b4 ();

  red_seq_ctrl #(.NIB_PER_CYC(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  red_seq_ctrl #(.NIB_PER_CYC(2)) dut2 (.clk(clk), .rst(rst), .bus(b2));
  red_seq_ctrl #(.NIB_PER_CYC(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operand pair to the NIB_PER_CYC=1 instance for a single edge.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b);
    b1.in_valid = 1'b1;
    b1.in_a     = a;
    b1.in_b     = b;
    tick();
    b1.in_valid = 1'b0;
  endtask

  task automatic waitValid(output int cycles);
    cycles = 0;
    while (!b1.out_valid && cycles < 20) begin
      tick();
      cycles++;
    end
  endtask

  task automatic handoff(input string tag);
    b1.out_ready = 1'b1;
    tick();
    b1.out_ready = 1'b0;
    checkOutput({tag, "_vld_after"}, 32'(b1.out_valid), 32'd0);
    checkOutput({tag, "_sum_after"}, 32'(b1.out_sum), 32'd0);
  endtask

  task automatic runOp(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] exp_sum, input int exp_lat);
    int lat;
    applyStimulus(a, b);
    checkOutput({tag, "_busy"}, 32'(b1.busy), 32'd1);
    checkOutput({tag, "_inrdy"}, 32'(b1.in_ready), 32'd0);
    waitValid(lat);
    checkOutput({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    checkOutput({tag, "_sum"}, 32'(b1.out_sum), 32'(exp_sum));
    handoff(tag);
  endtask

  initial begin
    int lat;
    int seen;
    int lat2;
    int lat4;
    logic [15:0] sum2;
    logic [15:0] sum4;

    errors = 0;
    checks = 0;
    b1.flush = 0; b1.in_valid = 0; b1.in_a = 0; b1.in_b = 0; b1.out_ready = 0;
    b2.flush = 0; b2.in_valid = 0; b2.in_a = 0; b2.in_b = 0; b2.out_ready = 0;
    b4.flush = 0; b4.in_valid = 0; b4.in_a = 0; b4.in_b = 0; b4.out_ready = 0;

    rst = 1'b1;
    #1;
    checkOutput("rst_inrdy", 32'(b1.in_ready), 32'd1);
    checkOutput("rst_vld", 32'(b1.out_valid), 32'd0);
    checkOutput("rst_busy", 32'(b1.busy), 32'd0);
    checkOutput("rst_sum", 32'(b1.out_sum), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    runOp("zero", 16'h0000, 16'h0000, 16'h0000, 4);
    runOp("max", 16'h7777, 16'h7777, 16'h0038, 4);
    runOp("min", 16'h8888, 16'h8888, 16'hFFC0, 4);
    runOp("mix", 16'h1234, 16'hF0F0, 16'h0008, 4);

    // Backpressure: result holds while in_valid is presented but ignored.
    applyStimulus(16'h1234, 16'hF0F0);
    waitValid(lat);
    checkOutput("bp_lat", 32'(lat), 32'd4);
    b1.in_valid = 1'b1;
    b1.in_a = 16'h5555;
    b1.in_b = 16'h5555;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("bp_vld", 32'(b1.out_valid), 32'd1);
      checkOutput("bp_sum", 32'(b1.out_sum), 32'h0008);
      checkOutput("bp_inrdy", 32'(b1.in_ready), 32'd0);
    end
    b1.in_a = 16'h1111;
    b1.in_b = 16'h0000;
    b1.out_ready = 1'b1;
    #1;
    checkOutput("b2b_inrdy", 32'(b1.in_ready), 32'd1);
    tick();
    b1.in_valid = 1'b0;
    b1.out_ready = 1'b0;
    checkOutput("b2b_vld", 32'(b1.out_valid), 32'd0);
    checkOutput("b2b_busy", 32'(b1.busy), 32'd1);
    waitValid(lat);
    checkOutput("b2b_lat", 32'(lat), 32'd4);
    checkOutput("b2b_sum", 32'(b1.out_sum), 32'h0004);
    handoff("b2b");

    // Flush during the second ACCUM cycle squashes the op.
    applyStimulus(16'h7777, 16'h7777);
    tick();
    b1.flush = 1'b1;
    tick();
    b1.flush = 1'b0;
    checkOutput("fl_busy", 32'(b1.busy), 32'd0);
    checkOutput("fl_inrdy", 32'(b1.in_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (b1.out_valid) seen++;
      tick();
    end
    checkOutput("fl_novld", 32'(seen), 32'd0);

    // Flush beats a simultaneous accept in IDLE.
    b1.flush = 1'b1;
    b1.in_valid = 1'b1;
    b1.in_a = 16'h7777;
    tick();
    b1.flush = 1'b0;
    b1.in_valid = 1'b0;
    checkOutput("fl_acc_busy", 32'(b1.busy), 32'd0);

    // Reset mid-ACCUM, then a clean op afterwards.
    applyStimulus(16'h8888, 16'h8888);
    tick();
    rst = 1'b1;
    #1;
    checkOutput("mr_vld", 32'(b1.out_valid), 32'd0);
    checkOutput("mr_busy", 32'(b1.busy), 32'd0);
    checkOutput("mr_inrdy", 32'(b1.in_ready), 32'd1);
    checkOutput("mr_sum", 32'(b1.out_sum), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    runOp("post", 16'h7777, 16'h1111, 16'h0020, 4);

    // Wider fold widths: same sum, shorter latency.
    b2.in_valid = 1'b1; b2.in_a = 16'h1234; b2.in_b = 16'hF0F0;
    b4.in_valid = 1'b1; b4.in_a = 16'h1234; b4.in_b = 16'hF0F0;
    tick();
    b2.in_valid = 1'b0;
    b4.in_valid = 1'b0;
    lat2 = -1;
    lat4 = -1;
    sum2 = '0;
    sum4 = '0;
    for (int c = 0; c < 10; c++) begin
      if (lat2 < 0 && b2.out_valid) begin lat2 = c; sum2 = b2.out_sum; end
      if (lat4 < 0 && b4.out_valid) begin lat4 = c; sum4 = b4.out_sum; end
      tick();
    end
    checkOutput("n2_lat", 32'(lat2), 32'd2);
    checkOutput("n2_sum", 32'(sum2), 32'h0008);
    checkOutput("n4_lat", 32'(lat4), 32'd1);
    checkOutput("n4_sum", 32'(sum4), 32'h0008);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
